// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin arbiter that shares one UART transmitter between NUM_REQ
// byte sources. One byte is accepted from the winner. It is launched with a single-cycle
// tx_valid, and no further launch happens until the transmitter reports tx_done.
//
// Optional feature: define UART_TX_ARB_TIMEOUT_EN to enable a WAIT-state watchdog. The
// watchdog aborts a frame after TIMEOUT_CYCLES and pulses err_timeout. Without the macro,
// err_timeout is tied low.

module uart_tx_arbiter #(
   parameter int unsigned NUM_REQ        = 4,
   parameter int unsigned DATA_W         = 8,
   parameter int unsigned TIMEOUT_CYCLES = 4096
) (
   input  logic                       clk,
   input  logic                       nrst,
   input  logic [NUM_REQ-1:0]         req_valid,
   input  logic [NUM_REQ*DATA_W-1:0]  req_data,
   output logic [NUM_REQ-1:0]         req_ready,
   output logic                       tx_valid,
   output logic [DATA_W-1:0]          tx_data,
   input  logic                       tx_done,
   output logic [$clog2(NUM_REQ)-1:0] grant_id,
   output logic                       arb_busy,
   output logic                       err_timeout
);

   localparam int unsigned    IdW    = $clog2(NUM_REQ);
   localparam logic [IdW-1:0] LastId = IdW'(NUM_REQ - 1);

   // Elaboration-time sanity check on the configuration
   if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1) begin : gen_param_err
      $error("uart_tx_arbiter: unsupported NUM_REQ or TIMEOUT_CYCLES");
   end

   typedef enum logic [1:0] {
      StIdle,
      StIssue,
      StWait
   } state_e;

   state_e             state_q, state_d;
   logic [IdW-1:0]     last_grant_q, last_grant_d;
   logic [IdW-1:0]     grant_id_q, grant_id_d;
   logic [DATA_W-1:0]  tx_data_q, tx_data_d;
   logic               tx_valid_q, tx_valid_d;
   logic               arb_busy_q, arb_busy_d;

   logic [IdW-1:0]     winner;
   logic [IdW-1:0]     scan_idx;
   logic               any_valid;
   logic               expire;
   logic [DATA_W-1:0]  req_bytes [NUM_REQ];

   // Unpack the flat request bus into one byte per requester
   for (genvar g = 0; g < NUM_REQ; g++) begin : gen_bytes
      assign req_bytes[g] = req_data[g*DATA_W +: DATA_W];
   end

   // Round-robin search starting just above the last grant, wrapping around
   always_comb begin
      winner    = '0;
      any_valid = 1'b0;
      scan_idx  = '0;
      for (int unsigned k = 1; k <= NUM_REQ; k++) begin
         scan_idx = IdW'((32'(last_grant_q) + k) % NUM_REQ);
         if (!any_valid && req_valid[scan_idx]) begin
            winner    = scan_idx;
            any_valid = 1'b1;
         end
      end
   end

   // One-hot accept strobe, only while idle and never while held in reset
   always_comb begin
      req_ready = '0;
      if (nrst && (state_q == StIdle) && any_valid) begin
         req_ready[winner] = 1'b1;
      end
   end

   // Next-state and registered-output logic
   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      grant_id_d   = grant_id_q;
      tx_data_d    = tx_data_q;
      tx_valid_d   = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (any_valid) begin
               state_d      = StIssue;
               tx_data_d    = req_bytes[winner];
               grant_id_d   = winner;
               last_grant_d = winner;
               tx_valid_d   = 1'b1;
            end
         end
         StIssue: begin
            // tx_done here belongs to no frame of ours and is ignored
            state_d = StWait;
         end
         StWait: begin
            if (tx_done || expire) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
      arb_busy_d = (state_d != StIdle);
   end

   // State and output registers
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state_q      <= StIdle;
         last_grant_q <= LastId;
         grant_id_q   <= '0;
         tx_data_q    <= '0;
         tx_valid_q   <= 1'b0;
         arb_busy_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         grant_id_q   <= grant_id_d;
         tx_data_q    <= tx_data_d;
         tx_valid_q   <= tx_valid_d;
         arb_busy_q   <= arb_busy_d;
      end
   end

`ifdef UART_TX_ARB_TIMEOUT_EN
   localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

   logic [CntW-1:0] wd_cnt_q, wd_cnt_d;
   logic            err_q, err_d;

   // Watchdog count: zero on the first WAIT cycle, +1 for every further WAIT cycle
   always_comb begin
      wd_cnt_d = wd_cnt_q;
      if (state_q == StIssue) begin
         wd_cnt_d = '0;
      end else if (state_q == StWait) begin
         wd_cnt_d = wd_cnt_q + CntW'(1);
      end
   end

   // The last allowed WAIT cycle is the one whose increment would reach TIMEOUT_CYCLES
   assign expire = (state_q == StWait) && (wd_cnt_q == CntW'(TIMEOUT_CYCLES - 1));
   // A tx_done on the expiry edge completes the frame normally
   assign err_d  = expire && !tx_done;

   // Watchdog counter and error pulse registers
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         wd_cnt_q <= '0;
         err_q    <= 1'b0;
      end else begin
         wd_cnt_q <= wd_cnt_d;
         err_q    <= err_d;
      end
   end

   assign err_timeout = err_q;
`else
   assign expire      = 1'b0;
   assign err_timeout = 1'b0;
`endif

   assign tx_valid = tx_valid_q;
   assign tx_data  = tx_data_q;
   assign grant_id = grant_id_q;
   assign arb_busy = arb_busy_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter (NUM_REQ=4, DATA_W=8, TIMEOUT_CYCLES=16).
// Expected grants are pushed to a scoreboard at the accept edge and popped in ISSUE.

module tb_uart_tx_arbiter;

   typedef struct packed {
      logic [1:0] id;
      logic [7:0] data;
   } exp_t;

   logic        clk = 1'b0;
   logic        nrst;
   logic [3:0]  req_valid;
   logic [31:0] req_data;
   logic [3:0]  req_ready;
   logic        tx_valid;
   logic [7:0]  tx_data;
   logic        tx_done;
   logic [1:0]  grant_id;
   logic        arb_busy;
   logic        err_timeout;

   int   total = 0;
   int   bad   = 0;
   int   model_last;
   exp_t sb_q[$];
   exp_t e;

   uart_tx_arbiter #(
      .NUM_REQ        (4),
      .DATA_W         (8),
      .TIMEOUT_CYCLES (16)
   ) dut (
      .clk         (clk),
      .nrst        (nrst),
      .req_valid   (req_valid),
      .req_data    (req_data),
      .req_ready   (req_ready),
      .tx_valid    (tx_valid),
      .tx_data     (tx_data),
      .tx_done     (tx_done),
      .grant_id    (grant_id),
      .arb_busy    (arb_busy),
      .err_timeout (err_timeout)
   );

   always #5 clk = ~clk;

   // Reference round-robin choice
   function automatic int predict(input logic [3:0] v, input int last);
      for (int k = 1; k <= 4; k++) begin
         int idx;
         idx = (last + k) % 4;
         if (v[idx]) return idx;
      end
      return -1;
   endfunction

   function automatic logic [7:0] byte_of(input logic [31:0] d, input int i);
      logic [31:0] s;
      s = d >> (i * 8);
      return s[7:0];
   endfunction

   function automatic logic [3:0] onehot(input int i);
      logic [3:0] r;
      r = 4'b0001 << i;
      return r;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      tick();
      nrst      = 1'b0;
      req_valid = '0;
      tx_done   = 1'b0;
      tick();
      tick();
      nrst       = 1'b1;
      model_last = 3;
      sb_q.delete();
   endtask

   task automatic test_reset();
      int w;
      nrst      = 1'b0;
      tx_done   = 1'b0;
      req_valid = 4'b0010;
      req_data  = 32'h44_33_A5_11;
      #2;
      tick();
      total++; if (tx_valid !== 1'b0) begin bad++; $display("FAIL rst_tx_valid got %b want 0", tx_valid); end
      total++; if (tx_data !== 8'h00) begin bad++; $display("FAIL rst_tx_data got %h want 00", tx_data); end
      total++; if (grant_id !== 2'd0) begin bad++; $display("FAIL rst_grant_id got %0d want 0", grant_id); end
      total++; if (arb_busy !== 1'b0) begin bad++; $display("FAIL rst_arb_busy got %b want 0", arb_busy); end
      total++; if (err_timeout !== 1'b0) begin bad++; $display("FAIL rst_err got %b want 0", err_timeout); end
      total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL rst_req_ready got %b want 0000", req_ready); end
      nrst       = 1'b1;
      model_last = 3;
      #1;
      w = predict(req_valid, model_last);
      total++; if (req_ready !== 4'b0010) begin bad++; $display("FAIL first_req_ready got %b want 0010", req_ready); end
      sb_q.push_back('{id: 2'(w), data: byte_of(req_data, w)});
      model_last = w;
      tick();
      req_valid = '0;
      e = sb_q.pop_front();
      total++; if (tx_valid !== 1'b1) begin bad++; $display("FAIL first_tx_valid got %b want 1", tx_valid); end
      total++; if (tx_data !== e.data) begin bad++; $display("FAIL first_tx_data got %h want %h", tx_data, e.data); end
      total++; if (grant_id !== e.id) begin bad++; $display("FAIL first_grant_id got %0d want %0d", grant_id, e.id); end
      total++; if (arb_busy !== 1'b1) begin bad++; $display("FAIL first_busy got %b want 1", arb_busy); end
      tick();
      total++; if (tx_valid !== 1'b0) begin bad++; $display("FAIL first_tx_valid_drop got %b want 0", tx_valid); end
      tx_done = 1'b1;
      tick();
      tx_done = 1'b0;
      total++; if (arb_busy !== 1'b0) begin bad++; $display("FAIL first_busy_done got %b want 0", arb_busy); end
   endtask

   task automatic test_round_robin();
      logic [3:0] vtab [14];
      int         order [8];
      int         w;
      vtab  = '{4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF,
                4'b1010, 4'b1010, 4'b0100, 4'b1001, 4'b0001, 4'b0110};
      order = '{0, 1, 2, 3, 0, 1, 2, 3};
      apply_reset();
      for (int f = 0; f < 14; f++) begin
         req_valid = vtab[f];
         req_data  = $urandom;
         #1;
         w = predict(req_valid, model_last);
         total++;
         if (req_ready !== onehot(w)) begin
            bad++; $display("FAIL rr_req_ready frame %0d got %b want %b", f, req_ready, onehot(w));
         end
         sb_q.push_back('{id: 2'(w), data: byte_of(req_data, w)});
         model_last = w;
         tick();
         req_valid = '0;
         e = sb_q.pop_front();
         total++; if (tx_valid !== 1'b1) begin bad++; $display("FAIL rr_tx_valid frame %0d got %b want 1", f, tx_valid); end
         total++; if (tx_data !== e.data) begin bad++; $display("FAIL rr_tx_data frame %0d got %h want %h", f, tx_data, e.data); end
         total++; if (grant_id !== e.id) begin bad++; $display("FAIL rr_grant frame %0d got %0d want %0d", f, grant_id, e.id); end
         if (f < 8) begin
            total++;
            if (grant_id !== 2'(order[f])) begin
               bad++; $display("FAIL rr_order frame %0d got %0d want %0d", f, grant_id, order[f]);
            end
         end
         total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL rr_ready_issue frame %0d got %b want 0000", f, req_ready); end
         tick();
         tx_done = 1'b1;
         tick();
         tx_done = 1'b0;
      end
   endtask

   task automatic test_done_in_issue();
      int w;
      req_valid = 4'b0001;
      req_data  = 32'h0BAD_F00D;
      #1;
      w = predict(req_valid, model_last);
      sb_q.push_back('{id: 2'(w), data: byte_of(req_data, w)});
      model_last = w;
      tick();
      tx_done = 1'b1;
      e = sb_q.pop_front();
      total++; if (tx_valid !== 1'b1) begin bad++; $display("FAIL dii_tx_valid got %b want 1", tx_valid); end
      total++; if (tx_data !== e.data) begin bad++; $display("FAIL dii_tx_data got %h want %h", tx_data, e.data); end
      tick();
      tx_done = 1'b0;
      for (int i = 0; i < 10; i++) begin
         total++; if (arb_busy !== 1'b1) begin bad++; $display("FAIL dii_busy cycle %0d got %b want 1", i, arb_busy); end
         total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL dii_ready cycle %0d got %b want 0000", i, req_ready); end
         tick();
      end
      tx_done = 1'b1;
      tick();
      tx_done = 1'b0;
      w = predict(req_valid, model_last);
      total++; if (arb_busy !== 1'b0) begin bad++; $display("FAIL dii_idle_busy got %b want 0", arb_busy); end
      total++; if (req_ready !== onehot(w)) begin bad++; $display("FAIL dii_idle_ready got %b want %b", req_ready, onehot(w)); end
      req_valid = '0;
   endtask

   task automatic test_reset_mid_wait();
      int w;
      req_valid = 4'b1000;
      req_data  = 32'hC3_B2_A1_90;
      #1;
      w = predict(req_valid, model_last);
      sb_q.push_back('{id: 2'(w), data: byte_of(req_data, w)});
      model_last = w;
      tick();
      req_valid = '0;
      e = sb_q.pop_front();
      total++; if (tx_data !== e.data) begin bad++; $display("FAIL rmw_tx_data got %h want %h", tx_data, e.data); end
      tick();
      total++; if (arb_busy !== 1'b1) begin bad++; $display("FAIL rmw_busy got %b want 1", arb_busy); end
      #2;
      req_valid = 4'b1100;
      nrst      = 1'b0;
      #1;
      total++; if (tx_data !== 8'h00) begin bad++; $display("FAIL rmw_tx_data_rst got %h want 00", tx_data); end
      total++; if (grant_id !== 2'd0) begin bad++; $display("FAIL rmw_grant_rst got %0d want 0", grant_id); end
      total++; if (arb_busy !== 1'b0) begin bad++; $display("FAIL rmw_busy_rst got %b want 0", arb_busy); end
      total++; if (tx_valid !== 1'b0) begin bad++; $display("FAIL rmw_tx_valid_rst got %b want 0", tx_valid); end
      total++; if (err_timeout !== 1'b0) begin bad++; $display("FAIL rmw_err_rst got %b want 0", err_timeout); end
      total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL rmw_ready_rst got %b want 0000", req_ready); end
      tick();
      nrst       = 1'b1;
      model_last = 3;
      sb_q.delete();
      #1;
      w = predict(req_valid, model_last);
      total++; if (req_ready !== 4'b0100) begin bad++; $display("FAIL rmw_ready_after got %b want 0100", req_ready); end
      sb_q.push_back('{id: 2'(w), data: byte_of(req_data, w)});
      model_last = w;
      tick();
      req_valid = '0;
      e = sb_q.pop_front();
      total++; if (grant_id !== e.id) begin bad++; $display("FAIL rmw_grant got %0d want %0d", grant_id, e.id); end
      total++; if (tx_data !== e.data) begin bad++; $display("FAIL rmw_data got %h want %h", tx_data, e.data); end
      tick();
      tx_done = 1'b1;
      tick();
      tx_done = 1'b0;
   endtask

`ifdef UART_TX_ARB_TIMEOUT_EN
   task automatic test_timeout();
      int w;
      int ok;
      req_valid = 4'b0010;
      req_data  = $urandom;
      #1;
      w = predict(req_valid, model_last);
      model_last = w;
      tick();
      req_valid = '0;
      tick();
      ok = 0;
      for (int i = 0; i < 16; i++) begin
         if (arb_busy === 1'b1 && err_timeout === 1'b0) ok++;
         tick();
      end
      total++; if (ok !== 16) begin bad++; $display("FAIL to_wait_cycles got %0d want 16", ok); end
      total++; if (err_timeout !== 1'b1) begin bad++; $display("FAIL to_err_pulse got %b want 1", err_timeout); end
      total++; if (arb_busy !== 1'b0) begin bad++; $display("FAIL to_busy got %b want 0", arb_busy); end
      req_valid = 4'hF;
      #1;
      w = predict(req_valid, model_last);
      total++; if (req_ready !== onehot(w)) begin bad++; $display("FAIL to_next_grant got %b want %b", req_ready, onehot(w)); end
      req_valid = '0;
      tick();
      total++; if (err_timeout !== 1'b0) begin bad++; $display("FAIL to_err_once got %b want 0", err_timeout); end
   endtask
`else
   task automatic test_long_wait();
      int w;
      int ok;
      req_valid = 4'b0001;
      req_data  = $urandom;
      #1;
      w = predict(req_valid, model_last);
      model_last = w;
      tick();
      req_valid = '0;
      tick();
      ok = 0;
      for (int i = 0; i < 10000; i++) begin
         if (arb_busy === 1'b1 && err_timeout === 1'b0 && tx_valid === 1'b0) ok++;
         tick();
      end
      total++; if (ok !== 10000) begin bad++; $display("FAIL lw_stuck_cycles got %0d want 10000", ok); end
      tx_done = 1'b1;
      tick();
      tx_done = 1'b0;
      total++; if (arb_busy !== 1'b0) begin bad++; $display("FAIL lw_release got %b want 0", arb_busy); end
   endtask
`endif

   initial begin
      test_reset();
      test_round_robin();
      test_done_in_issue();
      test_reset_mid_wait();
`ifdef UART_TX_ARB_TIMEOUT_EN
      test_timeout();
`else
      test_long_wait();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not complete, total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog expired");
   end

endmodule
